cp0_ctrl: RTL and testbench
===========================

Name: cp0_ctrl

Overview:
- Coprocessor-0 control block for the MIPS32 multi-cycle CPU.
- Sits at the other end of the next-PC selector's exception/return interface:
  - raises the interrupt request that makes control drive nPC_Op=101 (vector 0x0000_4180);
  - captures the resume address on exception entry;
  - supplies that address as the eret target for nPC_Op=100.
- Also serves mfc0/mtc0 register accesses.

Parameters:
- PRID, 32'h0000_0827, read-only processor ID returned at register 15.
- HWINT_W, 6, number of hardware interrupt lines; maps to SR.IM and Cause.IP bits [15:10].

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- pc_resume  input  32  address to resume at, sampled on exception entry.
- hw_int  input  HWINT_W  level-sensitive device interrupt lines.
- addr  input  5  CP0 register number for mfc0/mtc0.
- din  input  32  mtc0 write data.
- we  input  1  mtc0 write strobe, one cycle.
- exl_set  input  1  controller pulse: interrupt accepted, entering handler.
- exl_clr  input  1  controller pulse: eret executing.
- int_req  output  1  interrupt request to controller.
- eret_addr  output  32  EPC contents, feeds the next-PC selector.
- dout  output  32  mfc0 read data.

Behaviour:
- Registers:
  - SR (12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (13): IP[15:10] and ExcCode[6:2]; all other bits read 0.
  - EPC (14): bits [31:2] stored, bits [1:0] always 0.
  - PRId (15): constant PRID.
- Reset (async, rst=1): SR=0, Cause=0, EPC=0. Outputs while reset: int_req=0, eret_addr=0, dout combinational from addr (registers read 0; PRId still reads PRID).
- Cause.IP:
  - Loaded every clock edge with hw_int; sampled copy, one-cycle latency.
  - Not writable by mtc0. A write to 13 is ignored except ExcCode.
- int_req:
  - Combinational: |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
  - Asserts the cycle after a masked-in line rises, given IE=1 and EXL=0.
  - Holds until exl_set is taken or the line drops.
- Exception entry, on exl_set at edge: EPC <= {pc_resume[31:2],2'b00}; SR.EXL <= 1; ExcCode <= 0. int_req falls the following cycle.
- eret, on exl_clr at edge: SR.EXL <= 0. EPC unchanged.
- mtc0, on we at edge:
  - addr 12 writes IM/EXL/IE from din.
  - addr 13 writes ExcCode only.
  - addr 14 writes EPC with low bits forced to 0.
  - addr 15 and any other addr: no effect.
- Priority on the same edge:
  - EXL bit: exl_set > exl_clr > mtc0 write. IM and IE still take the mtc0 value.
  - EPC: exl_set > mtc0 write to 14.
  - exl_set and exl_clr together: net EXL=1, EPC captured.
- dout:
  - Combinational: addr 12/13/14/15 → SR/Cause/EPC/PRId.
  - Any other addr → 0.
  - Reflects register state before the current edge; no read-during-write bypass.
- eret_addr: continuously equals EPC.
- Nesting: none. While EXL=1, int_req=0 regardless of hw_int.
- Reset mid-handler: EXL cleared, EPC lost. int_req becomes 0 until software re-enables IE and IM.

Test Plan:
- Reset then read back:
  - Assert rst mid-operation; addr 12/13/14 → dout=0.
  - addr 15 → dout=0x0000_0827.
  - int_req=0 and eret_addr=0 throughout.
- Interrupt entry:
  - mtc0 SR=0x0000_0401 (IM[10], IE).
  - Drive hw_int=6'b000001 → int_req=1 one cycle later.
  - Pulse exl_set with pc_resume=0x0000_3024 → eret_addr=0x0000_3024, SR reads 0x0000_0403, int_req=0 next cycle.
- Masking:
  - SR=0x0000_0801 (IM[11] only) with hw_int=6'b000001 → int_req stays 0, Cause reads 0x0000_0400.
  - IE=0 with a matching line → int_req=0.
- eret:
  - From the in-handler state above, pulse exl_clr with hw_int still 1 → SR=0x0000_0401.
  - int_req reasserts the next cycle; eret_addr unchanged at 0x0000_3024.
- Collisions on the same edge:
  - exl_set plus mtc0 EPC=0x0000_5000 → EPC=pc_resume.
  - exl_set plus exl_clr → EXL=1.
  - mtc0 SR=0x0000_0401 plus exl_set → SR=0x0000_0403.
- Alignment and read-only:
  - mtc0 EPC=0x0000_3027 → reads 0x0000_3024.
  - mtc0 addr 15 = 0xFFFF_FFFF → PRId unchanged.
  - mtc0 Cause=0xFFFF_FFFF → IP still tracks hw_int, ExcCode reads 5'h1F.

Source files
------------

// File: rtl/cp0_ctrl.sv
// Coprocessor-0 control for the multi-cycle MIPS32 core: SR/Cause/EPC/PRId,
// interrupt request generation and exception-entry / eret bookkeeping.
module cp0_ctrl #(
    parameter logic [31:0] PRID    = 32'h0000_0827,
    parameter int          HWINT_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        pc_resume,
    input  logic [HWINT_W-1:0] hw_int,
    input  logic [4:0]         addr,
    input  logic [31:0]        din,
    input  logic               we,
    input  logic               exl_set,
    input  logic               exl_clr,
    output logic               int_req,
    output logic [31:0]        eret_addr,
    output logic [31:0]        dout
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [HWINT_W-1:0] im_q, im_d;
    logic [HWINT_W-1:0] ip_q, ip_d;
    logic               exl_q, exl_d;
    logic               ie_q, ie_d;
    logic [4:0]         exc_code_q, exc_code_d;
    logic [29:0]        epc_q, epc_d;

    logic [31:0] sr_rd;
    logic [31:0] cause_rd;
    logic [31:0] epc_rd;
    logic        unused_pc_lo;

    assign unused_pc_lo = ^pc_resume[1:0];

    // Later assignments win: mtc0 < exl_clr < exl_set for EXL and EPC.
    always_comb begin
        im_d       = im_q;
        ip_d       = hw_int;
        exl_d      = exl_q;
        ie_d       = ie_q;
        exc_code_d = exc_code_q;
        epc_d      = epc_q;
        if (we) begin
            case (addr)
                ADDR_SR: begin
                    im_d  = din[10 +: HWINT_W];
                    exl_d = din[1];
                    ie_d  = din[0];
                end
                ADDR_CAUSE: exc_code_d = din[6:2];
                ADDR_EPC:   epc_d      = din[31:2];
                default: ;
            endcase
        end
        if (exl_clr) begin
            exl_d = 1'b0;
        end
        if (exl_set) begin
            exl_d      = 1'b1;
            epc_d      = pc_resume[31:2];
            exc_code_d = 5'd0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            im_q       <= '0;
            ip_q       <= '0;
            exl_q      <= 1'b0;
            ie_q       <= 1'b0;
            exc_code_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            im_q       <= im_d;
            ip_q       <= ip_d;
            exl_q      <= exl_d;
            ie_q       <= ie_d;
            exc_code_q <= exc_code_d;
            epc_q      <= epc_d;
        end
    end

    always_comb begin
        sr_rd                   = 32'd0;
        sr_rd[10 +: HWINT_W]    = im_q;
        sr_rd[1]                = exl_q;
        sr_rd[0]                = ie_q;
        cause_rd                = 32'd0;
        cause_rd[10 +: HWINT_W] = ip_q;
        cause_rd[6:2]           = exc_code_q;
        epc_rd                  = {epc_q, 2'b00};
    end

    // Reads show pre-edge state; no forwarding of a same-cycle mtc0.
    always_comb begin
        case (addr)
            ADDR_SR:    dout = sr_rd;
            ADDR_CAUSE: dout = cause_rd;
            ADDR_EPC:   dout = epc_rd;
            ADDR_PRID:  dout = PRID;
            default:    dout = 32'd0;
        endcase
    end

    assign int_req   = (|(ip_q & im_q)) & ie_q & ~exl_q;
    assign eret_addr = epc_rd;

endmodule

// File: tb/tb_cp0_ctrl.sv
// Directed bench for cp0_ctrl: reset, interrupt entry/eret, masking,
// same-edge collisions, EPC alignment and read-only fields.
module tb_cp0_ctrl;

    logic        clk;
    logic        rst;
    logic [31:0] pc_resume;
    logic [5:0]  hw_int;
    logic [4:0]  addr;
    logic [31:0] din;
    logic        we;
    logic        exl_set;
    logic        exl_clr;
    logic        int_req;
    logic [31:0] eret_addr;
    logic [31:0] dout;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [31:0] PRID_EXP = 32'h0000_0827;

    cp0_ctrl #(.PRID(32'h0000_0827), .HWINT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .pc_resume (pc_resume),
        .hw_int    (hw_int),
        .addr      (addr),
        .din       (din),
        .we        (we),
        .exl_set   (exl_set),
        .exl_clr   (exl_clr),
        .int_req   (int_req),
        .eret_addr (eret_addr),
        .dout      (dout)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input string tag, input logic [31:0] exp);
        addr = a;
        #1;
        check(tag, dout, exp);
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        check(tag, {31'd0, int_req}, {31'd0, exp});
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we   = 1'b1;
        addr = a;
        din  = d;
        tick();
        we   = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        pc_resume = 32'd0;
        hw_int    = 6'd0;
        addr      = 5'd0;
        din       = 32'd0;
        we        = 1'b0;
        exl_set   = 1'b0;
        exl_clr   = 1'b0;
        #2 rst = 1'b1;
        #1;
        rd(5'd12, "rst_sr", 32'd0);
        rd(5'd13, "rst_cause", 32'd0);
        rd(5'd14, "rst_epc", 32'd0);
        rd(5'd15, "rst_prid", PRID_EXP);
        chk_irq("rst_irq", 1'b0);
        check("rst_eret", eret_addr, 32'd0);
        tick();
        tick();
        rst = 1'b0;

        // Interrupt entry
        mtc0(5'd12, 32'h0000_0401);
        rd(5'd12, "sr_wr", 32'h0000_0401);
        hw_int = 6'b000001;
        #1 chk_irq("irq_lat0", 1'b0);
        tick();
        chk_irq("irq_rise", 1'b1);
        rd(5'd13, "cause_ip", 32'h0000_0400);
        pc_resume = 32'h0000_3024;
        exl_set   = 1'b1;
        tick();
        exl_set = 1'b0;
        check("entry_eret", eret_addr, 32'h0000_3024);
        rd(5'd12, "entry_sr", 32'h0000_0403);
        chk_irq("entry_irq", 1'b0);
        tick();
        chk_irq("nest_irq", 1'b0);

        // eret with the line still high
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        rd(5'd12, "eret_sr", 32'h0000_0401);
        chk_irq("eret_irq", 1'b1);
        check("eret_epc", eret_addr, 32'h0000_3024);

        // Masking
        mtc0(5'd12, 32'h0000_0801);
        chk_irq("mask_im", 1'b0);
        rd(5'd13, "mask_cause", 32'h0000_0400);
        mtc0(5'd12, 32'h0000_0400);
        chk_irq("mask_ie", 1'b0);
        mtc0(5'd12, 32'h0000_0401);
        chk_irq("unmask", 1'b1);
        hw_int = 6'd0;
        tick();
        chk_irq("line_drop", 1'b0);
        rd(5'd13, "cause_clr", 32'd0);

        // exl_set beats an mtc0 to EPC; read shows pre-edge EPC
        we = 1'b1; addr = 5'd14; din = 32'h0000_5000;
        exl_set = 1'b1; pc_resume = 32'h0000_6008;
        #1 check("no_bypass", dout, 32'h0000_3024);
        tick();
        we = 1'b0; exl_set = 1'b0;
        check("col_epc", eret_addr, 32'h0000_6008);
        rd(5'd12, "col_epc_sr", 32'h0000_0403);

        // exl_set together with exl_clr
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        rd(5'd12, "clr_sr", 32'h0000_0401);
        exl_set = 1'b1; exl_clr = 1'b1; pc_resume = 32'h0000_7010;
        tick();
        exl_set = 1'b0; exl_clr = 1'b0;
        rd(5'd12, "setclr_sr", 32'h0000_0403);
        check("setclr_epc", eret_addr, 32'h0000_7010);

        // mtc0 SR together with exl_set
        exl_clr = 1'b1;
        tick();
        exl_clr = 1'b0;
        mtc0(5'd12, 32'h0000_0000);
        rd(5'd12, "sr_zero", 32'd0);
        we = 1'b1; addr = 5'd12; din = 32'h0000_0401;
        exl_set = 1'b1; pc_resume = 32'h0000_0100;
        tick();
        we = 1'b0; exl_set = 1'b0;
        rd(5'd12, "wr_set_sr", 32'h0000_0403);
        check("wr_set_epc", eret_addr, 32'h0000_0100);

        // mtc0 SR with EXL=1 together with exl_clr
        we = 1'b1; addr = 5'd12; din = 32'h0000_0403; exl_clr = 1'b1;
        tick();
        we = 1'b0; exl_clr = 1'b0;
        rd(5'd12, "wr_clr_sr", 32'h0000_0401);

        // Alignment and read-only fields
        mtc0(5'd14, 32'h0000_3027);
        rd(5'd14, "epc_align", 32'h0000_3024);
        check("epc_align_eret", eret_addr, 32'h0000_3024);
        mtc0(5'd15, 32'hFFFF_FFFF);
        rd(5'd15, "prid_ro", PRID_EXP);
        mtc0(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, "sr_mask", 32'h0000_FC03);
        mtc0(5'd12, 32'h0000_0401);
        hw_int = 6'b101010;
        mtc0(5'd13, 32'hFFFF_FFFF);
        rd(5'd13, "cause_wr", 32'h0000_A87C);
        hw_int = 6'd0;
        tick();
        rd(5'd13, "cause_ip_trk", 32'h0000_007C);
        exl_set = 1'b1; pc_resume = 32'h0000_3024;
        tick();
        exl_set = 1'b0;
        rd(5'd13, "exc_clr", 32'd0);
        rd(5'd12, "handler_sr", 32'h0000_0403);
        rd(5'd3, "unmapped", 32'd0);

        // Reset while in the handler
        hw_int = 6'b000001;
        tick();
        chk_irq("hdl_irq", 1'b0);
        #2 rst = 1'b1;
        #1;
        rd(5'd12, "mrst_sr", 32'd0);
        rd(5'd13, "mrst_cause", 32'd0);
        rd(5'd14, "mrst_epc", 32'd0);
        rd(5'd15, "mrst_prid", PRID_EXP);
        chk_irq("mrst_irq", 1'b0);
        check("mrst_eret", eret_addr, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk_irq("post_rst_irq", 1'b0);
        rd(5'd13, "post_rst_cause", 32'h0000_0400);
        rd(5'd12, "post_rst_sr", 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
